// File: rtl/uart_packet_rx_framer.sv
// uart_packet_rx_framer
// Parses SYNC/dest/src/len headers from a received byte stream and emits the
// payload as a framed byte stream with SoP/EoP markers. Packets that stall
// longer than TIMEOUT_CYCLES between bytes are abandoned with an error pulse.
module uart_packet_rx_framer #(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter logic [7:0]  SYNC_BYTE      = 8'h55
) (
  input  logic       ipClk,
  input  logic       ipReset,
  input  logic [7:0] ipRxData,
  input  logic       ipRxValid,
  output logic [7:0] opDestination,
  output logic [7:0] opSource,
  output logic [7:0] opLength,
  output logic [7:0] opData,
  output logic       opValid,
  output logic       opSoP,
  output logic       opEoP,
  output logic       opError
);

  localparam int unsigned      GAP_W    = $clog2(TIMEOUT_CYCLES + 1);
  // Gap value seen in the last idle cycle before expiry.
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DEST,
    S_SRC,
    S_LEN,
    S_DATA
  } state_t;

  state_t           state_q,   state_d;
  logic [GAP_W-1:0] gap_q,     gap_d;
  logic [7:0]       remain_q,  remain_d;
  logic [7:0]       dest_sh_q, dest_sh_d;
  logic [7:0]       src_sh_q,  src_sh_d;
  logic [7:0]       dest_q,    dest_d;
  logic [7:0]       src_q,     src_d;
  logic [7:0]       len_q,     len_d;
  logic [7:0]       data_q,    data_d;
  logic             valid_q,   valid_d;
  logic             sop_q,     sop_d;
  logic             eop_q,     eop_d;
  logic             err_q,     err_d;

  // State, counters and registered outputs.
  always_ff @(posedge ipClk) begin
    if (ipReset) begin
      state_q   <= S_IDLE;
      gap_q     <= '0;
      remain_q  <= '0;
      dest_sh_q <= '0;
      src_sh_q  <= '0;
      dest_q    <= '0;
      src_q     <= '0;
      len_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      remain_q  <= remain_d;
      dest_sh_q <= dest_sh_d;
      src_sh_q  <= src_sh_d;
      dest_q    <= dest_d;
      src_q     <= src_d;
      len_q     <= len_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      sop_q     <= sop_d;
      eop_q     <= eop_d;
      err_q     <= err_d;
    end
  end

  // Next-state, inter-byte timeout and output decode.
  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    remain_d  = remain_q;
    dest_sh_d = dest_sh_q;
    src_sh_d  = src_sh_q;
    dest_d    = dest_q;
    src_d     = src_q;
    len_d     = len_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    sop_d     = 1'b0;
    eop_d     = 1'b0;
    err_d     = 1'b0;

    // Timeout only fires on a byte-free cycle, so an arriving byte always wins.
    if (state_q != S_IDLE) begin
      if (ipRxValid) begin
        gap_d = '0;
      end else if (gap_q == GAP_LAST) begin
        gap_d   = '0;
        err_d   = 1'b1;
        state_d = S_IDLE;
      end else begin
        gap_d = gap_q + 1'b1;
      end
    end

    if (ipRxValid) begin
      case (state_q)
        S_IDLE: begin
          if (ipRxData == SYNC_BYTE) begin
            state_d = S_DEST;
          end
        end
        S_DEST: begin
          dest_sh_d = ipRxData;
          state_d   = S_SRC;
        end
        S_SRC: begin
          src_sh_d = ipRxData;
          state_d  = S_LEN;
        end
        S_LEN: begin
          // Header outputs change only here so they stay stable over the payload.
          dest_d   = dest_sh_q;
          src_d    = src_sh_q;
          len_d    = ipRxData;
          remain_d = ipRxData;
          state_d  = (ipRxData == 8'd0) ? S_IDLE : S_DATA;
        end
        S_DATA: begin
          data_d   = ipRxData;
          valid_d  = 1'b1;
          sop_d    = (remain_q == len_q);
          eop_d    = (remain_q == 8'd1);
          remain_d = remain_q - 8'd1;
          if (remain_q == 8'd1) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign opDestination = dest_q;
  assign opSource      = src_q;
  assign opLength      = len_q;
  assign opData        = data_q;
  assign opValid       = valid_q;
  assign opSoP         = sop_q;
  assign opEoP         = eop_q;
  assign opError       = err_q;

endmodule

// File: tb/tb_uart_packet_rx_framer.sv
// Self-checking bench for uart_packet_rx_framer with a packet-level reference
// model and a cycle-accurate scoreboard on the output strobes.
module tb_uart_packet_rx_framer;

  localparam int unsigned T    = 10;
  localparam logic [7:0]  SYNC = 8'h55;

  logic       ipClk = 1'b0;
  logic       ipReset = 1'b1;
  logic [7:0] ipRxData = 8'h00;
  logic       ipRxValid = 1'b0;
  logic [7:0] opDestination, opSource, opLength, opData;
  logic       opValid, opSoP, opEoP, opError;

  uart_packet_rx_framer #(
    .TIMEOUT_CYCLES(T),
    .SYNC_BYTE(SYNC)
  ) dut (
    .ipClk(ipClk),
    .ipReset(ipReset),
    .ipRxData(ipRxData),
    .ipRxValid(ipRxValid),
    .opDestination(opDestination),
    .opSource(opSource),
    .opLength(opLength),
    .opData(opData),
    .opValid(opValid),
    .opSoP(opSoP),
    .opEoP(opEoP),
    .opError(opError)
  );

  always #5 ipClk = ~ipClk;

  int cyc = 0;
  always @(posedge ipClk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    bit         err;
    logic [7:0] data;
    bit         sop;
    bit         eop;
    logic [7:0] dest;
    logic [7:0] src;
    logic [7:0] len;
  } ev_t;

  ev_t exp_q[$];
  int tests_run = 0;
  int tests_failed = 0;
  int exp_data_cnt = 0, exp_err_cnt = 0;
  int act_data_cnt = 0, act_err_cnt = 0;

  // Reference model: position within the packet, last byte arrival cycle.
  int         m_pos = 0;
  int         m_last = 0;
  logic [7:0] m_dest = 0, m_src = 0, m_len = 0;

  task automatic model_cycle(bit v, logic [7:0] b);
    int  k;
    int  idx;
    ev_t e;
    k = cyc + 1;
    if (m_pos != 0 && !v && (k - m_last) == int'(T)) begin
      e = '{cyc: k, err: 1'b1, data: 8'h00, sop: 1'b0, eop: 1'b0,
            dest: 8'h00, src: 8'h00, len: 8'h00};
      exp_q.push_back(e);
      exp_err_cnt++;
      m_pos = 0;
    end
    if (v) begin
      m_last = k;
      if (m_pos == 0) begin
        if (b == SYNC) m_pos = 1;
      end else if (m_pos == 1) begin
        m_dest = b; m_pos = 2;
      end else if (m_pos == 2) begin
        m_src = b; m_pos = 3;
      end else if (m_pos == 3) begin
        m_len = b;
        m_pos = (b == 8'd0) ? 0 : 4;
      end else begin
        idx = m_pos - 4;
        e = '{cyc: k, err: 1'b0, data: b, sop: (idx == 0),
              eop: (idx == int'(m_len) - 1), dest: m_dest, src: m_src, len: m_len};
        exp_q.push_back(e);
        exp_data_cnt++;
        m_pos = (idx + 1 == int'(m_len)) ? 0 : m_pos + 1;
      end
    end
  endtask

  task automatic drive(bit v, logic [7:0] b);
    model_cycle(v, b);
    ipRxValid = v;
    ipRxData  = b;
    @(negedge ipClk);
  endtask

  task automatic send(logic [7:0] b);
    drive(1'b1, b);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'($urandom));
  endtask

  task automatic apply_reset(int n);
    m_pos = 0;
    ipReset = 1'b1;
    ipRxValid = 1'b0;
    repeat (n) @(negedge ipClk);
    ipReset = 1'b0;
  endtask

  // Scoreboard: every opValid/opError cycle must match the model's next event.
  always @(negedge ipClk) begin
    ev_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      tests_run++;
      tests_failed++;
      $display("FAIL missing_event cyc=%0d got none required err=%0b data=%h", e.cyc, e.err, e.data);
    end
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      tests_run++;
      if (e.err) begin
        if ({opValid, opError} !== 2'b01) begin
          tests_failed++;
          $display("FAIL error_pulse cyc=%0d got valid/err=%b required 01", cyc, {opValid, opError});
        end
      end else if ({opValid, opError, opData, opSoP, opEoP, opDestination, opSource, opLength} !==
                   {2'b10, e.data, e.sop, e.eop, e.dest, e.src, e.len}) begin
        tests_failed++;
        $display("FAIL data_beat cyc=%0d got v=%b e=%b d=%h sop=%b eop=%b hdr=%h/%h/%h required d=%h sop=%b eop=%b hdr=%h/%h/%h",
                 cyc, opValid, opError, opData, opSoP, opEoP, opDestination, opSource, opLength,
                 e.data, e.sop, e.eop, e.dest, e.src, e.len);
      end
    end else if (opValid || opError) begin
      tests_run++;
      tests_failed++;
      $display("FAIL unexpected_strobe cyc=%0d got valid=%b err=%b data=%h required no strobe",
               cyc, opValid, opError, opData);
    end
    if (opValid) act_data_cnt++;
    if (opError) act_err_cnt++;
  end

  task automatic test_reset();
    repeat (3) @(negedge ipClk);
    tests_run++;
    if ({opDestination, opSource, opLength, opData, opValid, opSoP, opEoP, opError} !== 36'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs got %h required 0",
               {opDestination, opSource, opLength, opData, opValid, opSoP, opEoP, opError});
    end
    ipReset = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] s [7] = '{8'h55, 8'h0A, 8'h0B, 8'h03, 8'h11, 8'h22, 8'h33};
    int d0 = act_data_cnt;
    foreach (s[i]) send(s[i]);
    idle(3);
    tests_run++;
    if (act_data_cnt - d0 !== 3) begin
      tests_failed++;
      $display("FAIL basic_count got %0d required 3", act_data_cnt - d0);
    end
    tests_run++;
    if ({opDestination, opSource, opLength} !== 24'h0A0B03) begin
      tests_failed++;
      $display("FAIL basic_header_hold got %h required 0a0b03", {opDestination, opSource, opLength});
    end
  endtask

  task automatic test_garbage();
    logic [7:0] s [7] = '{8'h00, 8'hFF, 8'h55, 8'h01, 8'h02, 8'h01, 8'h55};
    int d0 = act_data_cnt;
    foreach (s[i]) send(s[i]);
    idle(3);
    tests_run++;
    if (act_data_cnt - d0 !== 1) begin
      tests_failed++;
      $display("FAIL garbage_count got %0d required 1", act_data_cnt - d0);
    end
  endtask

  task automatic test_empty();
    logic [7:0] a [4] = '{8'h55, 8'h01, 8'h02, 8'h00};
    logic [7:0] b [6] = '{8'h55, 8'h03, 8'h04, 8'h02, 8'hAA, 8'hBB};
    int d0 = act_data_cnt;
    int e0 = act_err_cnt;
    foreach (a[i]) send(a[i]);
    tests_run++;
    if ({opDestination, opSource, opLength} !== 24'h010200) begin
      tests_failed++;
      $display("FAIL empty_header got %h required 010200", {opDestination, opSource, opLength});
    end
    foreach (b[i]) send(b[i]);
    idle(3);
    tests_run++;
    if ((act_data_cnt - d0 !== 2) || (act_err_cnt - e0 !== 0)) begin
      tests_failed++;
      $display("FAIL empty_counts got data=%0d err=%0d required data=2 err=0",
               act_data_cnt - d0, act_err_cnt - e0);
    end
  endtask

  task automatic test_timeout();
    logic [7:0] a [5] = '{8'h55, 8'h01, 8'h02, 8'h04, 8'hAA};
    logic [7:0] b [6] = '{8'h55, 8'h09, 8'h08, 8'h02, 8'hC1, 8'hC2};
    int d0 = act_data_cnt;
    int e0 = act_err_cnt;
    foreach (a[i]) send(a[i]);
    idle(T + 3);
    tests_run++;
    if ((act_data_cnt - d0 !== 1) || (act_err_cnt - e0 !== 1)) begin
      tests_failed++;
      $display("FAIL timeout_counts got data=%0d err=%0d required data=1 err=1",
               act_data_cnt - d0, act_err_cnt - e0);
    end
    foreach (b[i]) send(b[i]);
    idle(3);
    tests_run++;
    if ((act_data_cnt - d0 !== 3) || (act_err_cnt - e0 !== 1)) begin
      tests_failed++;
      $display("FAIL timeout_recover got data=%0d err=%0d required data=3 err=1",
               act_data_cnt - d0, act_err_cnt - e0);
    end
  endtask

  task automatic test_boundary();
    logic [7:0] s [6] = '{8'h55, 8'h01, 8'h02, 8'h02, 8'hD0, 8'hD1};
    int d0 = act_data_cnt;
    int e0 = act_err_cnt;
    foreach (s[i]) begin
      if (i != 0) idle(T - 1);
      send(s[i]);
    end
    idle(3);
    tests_run++;
    if ((act_data_cnt - d0 !== 2) || (act_err_cnt - e0 !== 0)) begin
      tests_failed++;
      $display("FAIL boundary_spacing_T got data=%0d err=%0d required data=2 err=0",
               act_data_cnt - d0, act_err_cnt - e0);
    end
    send(8'h55);
    idle(T);
    send(8'h01);
    idle(3);
    tests_run++;
    if ((act_data_cnt - d0 !== 2) || (act_err_cnt - e0 !== 1)) begin
      tests_failed++;
      $display("FAIL boundary_spacing_T1 got data=%0d err=%0d required data=2 err=1",
               act_data_cnt - d0, act_err_cnt - e0);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] a [5] = '{8'h55, 8'h01, 8'h02, 8'h03, 8'hAA};
    logic [7:0] b [5] = '{8'h55, 8'h05, 8'h06, 8'h01, 8'h77};
    int d0, e0;
    foreach (a[i]) send(a[i]);
    apply_reset(1);
    tests_run++;
    if ({opDestination, opSource, opLength, opData, opValid, opSoP, opEoP, opError} !== 36'd0) begin
      tests_failed++;
      $display("FAIL reset_mid_outputs got %h required 0",
               {opDestination, opSource, opLength, opData, opValid, opSoP, opEoP, opError});
    end
    d0 = act_data_cnt;
    e0 = act_err_cnt;
    send(8'hBB);
    send(8'hCC);
    idle(T + 2);
    tests_run++;
    if ((act_data_cnt - d0 !== 0) || (act_err_cnt - e0 !== 0)) begin
      tests_failed++;
      $display("FAIL reset_mid_quiet got data=%0d err=%0d required 0/0",
               act_data_cnt - d0, act_err_cnt - e0);
    end
    foreach (b[i]) send(b[i]);
    idle(2);
    tests_run++;
    if (act_data_cnt - d0 !== 1) begin
      tests_failed++;
      $display("FAIL reset_mid_recover got %0d required 1", act_data_cnt - d0);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] s [18] = '{8'h55, 8'h10, 8'h20, 8'h02, 8'hA1, 8'hA2,
                           8'h55, 8'h11, 8'h21, 8'h01, 8'hB1,
                           8'h55, 8'h12, 8'h22, 8'h03, 8'h55, 8'h55, 8'h55};
    int d0 = act_data_cnt;
    foreach (s[i]) send(s[i]);
    idle(3);
    tests_run++;
    if (act_data_cnt - d0 !== 6) begin
      tests_failed++;
      $display("FAIL back_to_back_count got %0d required 6", act_data_cnt - d0);
    end
  endtask

  function automatic int pick_gap();
    int r = int'($urandom_range(0, 19));
    if (r < 14) return r % 3;
    if (r < 17) return int'(T) - 1;
    if (r < 19) return int'(T);
    return int'(T) + 2;
  endfunction

  task automatic test_random();
    int d0 = act_data_cnt;
    int e0 = act_err_cnt;
    int xd0 = exp_data_cnt;
    int xe0 = exp_err_cnt;
    for (int p = 0; p < 150; p++) begin
      logic [7:0] g;
      int         len;
      if ($urandom_range(0, 39) == 0) apply_reset(1);
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
        g = 8'($urandom);
        if (g == SYNC) g = 8'h00;
        send(g);
      end
      len = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 12));
      send(SYNC);
      idle(pick_gap()); send(8'($urandom));
      idle(pick_gap()); send(8'($urandom));
      idle(pick_gap()); send(8'(len));
      for (int j = 0; j < len; j++) begin
        idle(pick_gap());
        send(8'($urandom));
      end
      idle(pick_gap());
    end
    idle(T + 3);
    tests_run++;
    if ((act_data_cnt - d0 !== exp_data_cnt - xd0) || (act_err_cnt - e0 !== exp_err_cnt - xe0)) begin
      tests_failed++;
      $display("FAIL random_totals got data=%0d err=%0d required data=%0d err=%0d",
               act_data_cnt - d0, act_err_cnt - e0, exp_data_cnt - xd0, exp_err_cnt - xe0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_garbage();
    test_empty();
    test_timeout();
    test_boundary();
    test_reset_mid();
    test_back_to_back();
    test_random();
    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
